// File: rtl/crc16_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc16_ctrl_pkg
// Purpose  : Shared state encoding and constants for the CRC16 sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package crc16_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CRC   = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int   CRC_BITS = 16;
  localparam logic MODE_TX  = 1'b0;
  localparam logic MODE_RX  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/crc16_stall_wdt.sv
`default_nettype none
// ============================================================================
// Module   : crc16_stall_wdt
// Purpose  : Counts consecutive stalled sequencing cycles; fires on the
//            STALL_LIMIT-th one.
// Revision : 1.0 - initial release
// ============================================================================
module crc16_stall_wdt #(
  parameter int STALL_LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_stall,
  output logic o_fire
);

  localparam int CW = $clog2(STALL_LIMIT + 1);

  logic [CW-1:0] r_cnt;

  assign o_fire = i_active && i_stall && (r_cnt == CW'(STALL_LIMIT - 1));

  // The run restarts on any unstalled cycle and after firing, so the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_active || !i_stall || o_fire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/crc16_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : crc16_seq_ctrl
// Purpose  : Sequences seed/compute/shift-out/check controls of a serial
//            USB CRC16 engine. Optional stall watchdog: CRC16_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module crc16_seq_ctrl
  import crc16_ctrl_pkg::*;
#(
  parameter int MAX_BYTES_W = 10,
  parameter int STALL_LIMIT = 64
) (
  input  logic                   clk_c,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode,
  input  logic [MAX_BYTES_W-1:0] byte_cnt,
  input  logic                   stall,
  input  logic                   abort,
  input  logic                   crc_error,
  output logic                   crc_rst,
  output logic                   crc_cwe_z,
  output logic                   crc_halt,
  output logic                   crc_chck,
  output logic                   busy,
  output logic                   crc_phase,
  output logic                   done,
  output logic                   crc_ok,
  output logic                   crc_err,
  output logic                   timeout
);

  localparam int BW = MAX_BYTES_W + 3;

  state_t          r_state;
  state_t          w_next;
  logic            r_mode;
  logic [BW-1:0]   r_bit_total;
  logic [BW-1:0]   r_bit_cnt;
  logic            r_ok;
  logic            r_err;
  logic            w_accept;
  logic            w_active;
  logic            w_adv;
  logic            w_kill;
  logic            w_last_data;
  logic            w_last_crc;
  logic            w_wdt_fire;

  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_active    = (r_state == ST_DATA) || (r_state == ST_CRC);
  assign w_adv       = w_active && !stall;
  assign w_kill      = (r_state != ST_IDLE) && (abort || w_wdt_fire);
  assign w_last_data = (r_bit_cnt == r_bit_total - BW'(1));
  assign w_last_crc  = (r_bit_cnt == BW'(CRC_BITS - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_SEED;
      ST_SEED:  w_next = (r_bit_total == '0) ? ST_CRC : ST_DATA;
      ST_DATA:  if (!stall && w_last_data) w_next = ST_CRC;
      ST_CRC:   if (!stall && w_last_crc) w_next = (r_mode == MODE_RX) ? ST_CHECK : ST_DONE;
      ST_CHECK: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (w_kill) begin
      w_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk_c) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_TX;
      r_bit_total <= '0;
      r_bit_cnt   <= '0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode      <= mode;
        r_bit_total <= {byte_cnt, 3'b000};
        r_ok        <= 1'b0;
        r_err       <= 1'b0;
      end
      // One counter serves both the payload bits and the 16 CRC bits.
      if (r_state == ST_SEED) begin
        r_bit_cnt <= '0;
      end else if (w_adv) begin
        if ((r_state == ST_DATA && w_last_data) || (r_state == ST_CRC && w_last_crc)) begin
          r_bit_cnt <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
        end
      end
      if (r_state == ST_CHECK && !w_kill) begin
        r_ok  <= !crc_error;
        r_err <= crc_error;
      end
    end
  end

`ifdef CRC16_TIMEOUT_EN
  logic r_timeout;

  crc16_stall_wdt #(
    .STALL_LIMIT (STALL_LIMIT)
  ) u_wdt (
    .clk      (clk_c),
    .rst      (reset),
    .i_active (w_active),
    .i_stall  (stall),
    .o_fire   (w_wdt_fire)
  );

  always_ff @(posedge clk_c) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else if (w_accept) begin
      r_timeout <= 1'b0;
    end else if (w_wdt_fire) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_wdt_fire = 1'b0;
  assign timeout    = 1'b0;
`endif

  // The engine is reseeded on the abort cycle so the next packet starts clean.
  assign crc_rst   = reset || (r_state == ST_SEED) || w_kill;
  assign crc_cwe_z = (r_state == ST_CRC) && (r_mode == MODE_TX);
  assign crc_halt  = w_active && stall;
  assign crc_chck  = (r_state == ST_CHECK);
  assign busy      = (r_state != ST_IDLE);
  assign crc_phase = (r_state == ST_CRC);
  assign done      = (r_state == ST_DONE) && !w_kill;
  assign crc_ok    = r_ok;
  assign crc_err   = r_err;

endmodule
`default_nettype wire

// File: doc/crc16_seq_ctrl.md
Name: crc16_seq_ctrl

Overview:
Sequencer for the USB 2.0 serial CRC16 engine (crc_16) on DATA0/DATA1 packets.
- Generates the engine's seed, compute/shift-out, halt and check controls from a per-packet byte count and a bit-stuffer stall.
- TX: signals when the 16 CRC bits go out on the wire.
- RX: reports pass/fail on the received CRC residual.
- Sits between the packet-level TX/RX FSMs and crc_16.

Parameters:
MAX_BYTES_W, 10, width of byte_cnt; max payload 2^MAX_BYTES_W-1 bytes (1023 covers USB 2.0 isochronous max of 1024 only if widened to 11)
STALL_LIMIT, 64, consecutive stall cycles before timeout (only with CRC16_TIMEOUT_EN)

Ports:
clk_c  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse: begin packet; ignored while busy=1
mode  in  1  sampled with start: 0=TX, 1=RX
byte_cnt  in  MAX_BYTES_W  payload bytes, sampled with start; 0 legal (CRC-only packet)
stall  in  1  bit-stuffer stall; freezes sequencing in DATA/CRC
abort  in  1  cancel current packet
crc_error  in  1  error output of crc_16
crc_rst  out  1  drives crc_16 reset (seed all-ones)
crc_cwe_z  out  1  drives crc_16 cwe_z (0=compute, 1=shift CRC out)
crc_halt  out  1  drives crc_16 halt_tx
crc_chck  out  1  drives crc_16 chck_enbl
busy  out  1  high from cycle after start until done cycle inclusive
crc_phase  out  1  high while CRC bits are on the wire (TX) / being received (RX)
done  out  1  one-cycle completion pulse
crc_ok  out  1  RX result pass; held until next accepted start
crc_err  out  1  RX result fail; held until next accepted start
timeout  out  1  stall watchdog fired; held until next accepted start (0 when macro absent)

Behaviour:
- Reset: state IDLE; all outputs 0 except crc_rst=1 while reset is high.
- States: IDLE, SEED, DATA, CRC, CHECK, DONE.
- IDLE:
  - On start, latch mode and bit_total = byte_cnt*8 (width MAX_BYTES_W+3, no overflow).
  - Clear crc_ok, crc_err and timeout; go to SEED.
- SEED: one cycle, crc_rst=1; go to DATA, or to CRC if bit_total==0.
- DATA:
  - crc_cwe_z=0; bit counter increments on each cycle with stall=0.
  - Leave to CRC on the cycle the counter reaches bit_total-1 with stall=0.
- CRC:
  - 16 unstalled cycles; crc_phase=1.
  - TX: crc_cwe_z=1. RX: crc_cwe_z=0 (the residual is computed in place).
  - After the 16th bit: TX goes to DONE, RX goes to CHECK.
- CHECK (RX only):
  - One cycle, crc_chck=1.
  - crc_error is sampled at the end of this cycle: 0 sets crc_ok, 1 sets crc_err.
  - Go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- crc_halt = stall while in DATA or CRC, else 0. stall in any other state is ignored.
- Latency from the start edge to the done cycle, no stalls, N bytes:
  - TX: 8N+18 cycles.
  - RX: 8N+19 cycles.
  - Each stall cycle adds 1.
- crc_cwe_z stays 1 during a TX stall inside CRC (the engine freezes via halt).
- abort: from any non-IDLE state, go to IDLE next cycle. No done, results stay 0, crc_rst asserted for that one cycle.
- Priority: reset > abort > stall > normal advance.
- start coinciding with the DONE cycle is ignored. start is accepted only in IDLE.

Optional Feature:
CRC16_TIMEOUT_EN:
- Present: a counter tracks consecutive stall cycles in DATA/CRC and clears on any unstalled cycle.
  - Reaching STALL_LIMIT sets timeout and forces the abort path (IDLE next cycle, no done).
  - A stall run of exactly STALL_LIMIT-1 cycles continues normally.
- Absent: no counter, timeout tied 0, stalls unbounded.

Decomposition:
- Package crc16_ctrl_pkg holds:
  - the state enum (IDLE, SEED, DATA, CRC, CHECK, DONE);
  - CRC_BITS=16;
  - MODE_TX=0 / MODE_RX=1 constants.
- One sub-module, crc16_stall_wdt (stall run counter plus limit compare), instantiated only under CRC16_TIMEOUT_EN.
- The main FSM and bit counter stay in crc16_seq_ctrl.

Test Plan:
- TX, byte_cnt=2, no stall -> crc_rst high 1 cycle; crc_cwe_z=0 for 16 cycles, then 1 for 16 cycles; done at start+34; crc_ok=crc_err=0.
- RX, byte_cnt=1, crc_16 fed a payload with valid CRC -> crc_chck pulse at start+26; done at start+27; crc_ok=1.
- RX, byte_cnt=1, one flipped bit -> crc_err=1, crc_ok=0, held until next start.
- TX, byte_cnt=0 -> SEED goes straight to CRC; 16 cycles with crc_cwe_z=1; done at start+18.
- TX, byte_cnt=1, stall for 3 cycles mid-DATA and 2 cycles mid-CRC -> crc_halt matches stall exactly; done at start+31; start during busy ignored.
- abort at DATA bit 5 -> IDLE next cycle, no done. With CRC16_TIMEOUT_EN and STALL_LIMIT=8: 8-cycle stall gives timeout=1 with no done; 7-cycle stall completes normally.
